// File: rtl/chip_pkg.sv
// rtl/chip_pkg.sv - shared command and bank-state types for chip_burst
package chip_pkg;

   // Command encoding on the cmd port; unused encodings behave as NOP.
   typedef enum logic [2:0] {
      NOP = 3'd0,
      ACT = 3'd1,
      RD  = 3'd2,
      WR  = 3'd3,
      PRE = 3'd4
   } cmd_t;

   // Per-bank open/closed state.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } bank_state_t;

   // Width of the tRCD and latency down-counters; wide enough for any sane timing.
   localparam int CNTW = 16;

endpackage

// File: rtl/bank_fsm.sv
// rtl/bank_fsm.sv - one bank: open/closed state, open row and tRCD countdown
module bank_fsm
   import chip_pkg::*;
#(
   parameter int CHWIDTH = 5,
   parameter int TRCD    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               act_i,
   input  logic               pre_i,
   input  logic [CHWIDTH-1:0] row_i,
   output bank_state_t        state_o,
   output logic [CHWIDTH-1:0] row_o,
   output logic               ready_o
);

   bank_state_t        state_q, state_d;
   logic [CHWIDTH-1:0] row_q, row_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;

   // Next state: ACT opens the row and arms tRCD, PRE closes; the counter
   // runs down every cycle regardless of what the sequencer is doing.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
      if (act_i) begin
         state_d = ACTIVE;
         row_d   = row_i;
         cnt_d   = CNTW'(TRCD);
      end else if (pre_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // State registers, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;
   assign row_o   = row_q;
   assign ready_o = (state_q == ACTIVE) && (cnt_q == '0);

endmodule

// File: rtl/chip_burst.sv
// rtl/chip_burst.sv - command decode, burst sequencer and memory array
module chip_burst
   import chip_pkg::*;
#(
   parameter int BGWIDTH      = 2,
   parameter int BAWIDTH      = 2,
   parameter int CHWIDTH      = 5,
   parameter int COLWIDTH     = 10,
   parameter int DEVICE_WIDTH = 4,
   parameter int BL           = 8,
   parameter int TRCD         = 2,
   parameter int TCL          = 3,
   parameter int TCWL         = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  cmd_t                    cmd,
   input  logic [BGWIDTH-1:0]      bg,
   input  logic [BAWIDTH-1:0]      ba,
   input  logic [CHWIDTH-1:0]      row,
   input  logic [COLWIDTH-1:0]     col,
   input  logic [DEVICE_WIDTH-1:0] dqin,
   output logic [DEVICE_WIDTH-1:0] dqout,
   output logic                    dq_valid,
   output logic                    cmd_err
);

   localparam int BKW   = BGWIDTH + BAWIDTH;
   localparam int NBANK = 1 << BKW;
   localparam int AW    = BKW + CHWIDTH + COLWIDTH;

   localparam logic [1:0] SEQ_IDLE  = 2'd0;
   localparam logic [1:0] SEQ_LAT   = 2'd1;
   localparam logic [1:0] SEQ_BURST = 2'd2;

   // Low column bits that wrap within one BL-aligned block; also the last beat index.
   localparam logic [COLWIDTH-1:0] BEAT_MASK = COLWIDTH'(BL - 1);

   // The BURST state covers exactly the beat cycles, so a latency of 1 skips
   // LAT and a latency of L spends L-1 cycles there.
   localparam bit            RD_DIRECT = (TCL <= 1);
   localparam bit            WR_DIRECT = (TCWL <= 1);
   localparam logic [CNTW-1:0] RD_WAIT = CNTW'((TCL > 1) ? TCL - 2 : 0);
   localparam logic [CNTW-1:0] WR_WAIT = CNTW'((TCWL > 1) ? TCWL - 2 : 0);

   // Per-bank status.
   bank_state_t        bank_state [NBANK];
   logic [CHWIDTH-1:0] bank_row   [NBANK];
   logic [NBANK-1:0]   bank_ready;
   logic [NBANK-1:0]   bank_act;
   logic [NBANK-1:0]   bank_pre;

   // Command decode.
   logic [BKW-1:0] sel;
   logic           accept;
   logic           act_ok, pre_ok, rw_ok, illegal;

   // Sequencer registers.
   logic [1:0]          seq_q, seq_d;
   logic [CNTW-1:0]     wait_q, wait_d;
   logic [COLWIDTH-1:0] beat_q, beat_d;
   logic                rd_q, rd_d;
   logic [BKW-1:0]      bank_q, bank_d;
   logic [CHWIDTH-1:0]  brow_q, brow_d;
   logic [COLWIDTH-1:0] col_q, col_d;
   logic                err_q;

   // Datapath.
   logic [COLWIDTH-1:0]     beat_col;
   logic [AW-1:0]           mem_addr;
   logic                    wr_en;
   logic [DEVICE_WIDTH-1:0] mem [0:(1<<AW)-1];

   assign sel       = {bg, ba};
   assign cmd_ready = (seq_q == SEQ_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Classify the accepted command against the addressed bank's status.
   always_comb begin
      act_ok  = 1'b0;
      pre_ok  = 1'b0;
      rw_ok   = 1'b0;
      illegal = 1'b0;
      if (accept) begin
         case (cmd)
            ACT: begin
               if (bank_state[sel] == IDLE) act_ok = 1'b1;
               else                         illegal = 1'b1;
            end
            PRE: pre_ok = 1'b1;
            RD, WR: begin
               if (bank_ready[sel]) rw_ok = 1'b1;
               else                 illegal = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bank_act = act_ok ? (NBANK'(1) << sel) : '0;
   assign bank_pre = pre_ok ? (NBANK'(1) << sel) : '0;

   for (genvar i = 0; i < NBANK; i++) begin : g_bank
      bank_fsm #(
         .CHWIDTH (CHWIDTH),
         .TRCD    (TRCD)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .act_i   (bank_act[i]),
         .pre_i   (bank_pre[i]),
         .row_i   (row),
         .state_o (bank_state[i]),
         .row_o   (bank_row[i]),
         .ready_o (bank_ready[i])
      );
   end

   // Burst sequencer: latch the target on a legal RD/WR, wait out the
   // latency, then step through BL beats and return to IDLE.
   always_comb begin
      seq_d  = seq_q;
      wait_d = wait_q;
      beat_d = beat_q;
      rd_d   = rd_q;
      bank_d = bank_q;
      brow_d = brow_q;
      col_d  = col_q;
      case (seq_q)
         SEQ_IDLE: begin
            if (rw_ok) begin
               rd_d   = (cmd == RD);
               bank_d = sel;
               brow_d = bank_row[sel];
               col_d  = col;
               beat_d = '0;
               if (cmd == RD) begin
                  seq_d  = RD_DIRECT ? SEQ_BURST : SEQ_LAT;
                  wait_d = RD_WAIT;
               end else begin
                  seq_d  = WR_DIRECT ? SEQ_BURST : SEQ_LAT;
                  wait_d = WR_WAIT;
               end
            end
         end
         SEQ_LAT: begin
            if (wait_q == '0) seq_d = SEQ_BURST;
            else              wait_d = wait_q - CNTW'(1);
         end
         SEQ_BURST: begin
            if (beat_q == BEAT_MASK) seq_d = SEQ_IDLE;
            else                     beat_d = beat_q + COLWIDTH'(1);
         end
         default: seq_d = SEQ_IDLE;
      endcase
   end

   // Sequencer and error-pulse registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q  <= SEQ_IDLE;
         wait_q <= '0;
         beat_q <= '0;
         rd_q   <= 1'b0;
         bank_q <= '0;
         brow_q <= '0;
         col_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         seq_q  <= seq_d;
         wait_q <= wait_d;
         beat_q <= beat_d;
         rd_q   <= rd_d;
         bank_q <= bank_d;
         brow_q <= brow_d;
         col_q  <= col_d;
         err_q  <= illegal;
      end
   end

   // Beat column keeps the block-aligned upper bits and wraps the low bits.
   assign beat_col = (col_q & ~BEAT_MASK) | ((col_q + beat_q) & BEAT_MASK);
   assign mem_addr = {bank_q, brow_q, beat_col};
   assign wr_en    = (seq_q == SEQ_BURST) && !rd_q;

   // Storage array: written one beat per cycle during a write burst, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[mem_addr] <= dqin;
   end

   assign dq_valid = (seq_q == SEQ_BURST) && rd_q;
   assign dqout    = dq_valid ? mem[mem_addr] : '0;
   assign cmd_err  = err_q;

endmodule

// File: tb/tb_chip_burst.sv
// tb/tb_chip_burst.sv - directed scoreboard bench for chip_burst
module tb_chip_burst;
   import chip_pkg::*;

   localparam int TRCD = 2;
   localparam int TCL  = 3;
   localparam int TCWL = 1;
   localparam int BL   = 8;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       cmd_valid = 1'b0;
   cmd_t       cmd       = NOP;
   logic [1:0] bg        = '0;
   logic [1:0] ba        = '0;
   logic [4:0] row       = '0;
   logic [9:0] col       = '0;
   logic [3:0] dqin      = '0;
   logic       cmd_ready;
   logic [3:0] dqout;
   logic       dq_valid;
   logic       cmd_err;

   typedef struct {
      logic [3:0] d;
      int         c;
   } beat_t;

   beat_t exp_q[$];
   int    err_q[$];
   int    cyc  = 0;
   int    nvec = 0;
   int    nmis = 0;

   chip_burst #(
      .BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(5), .COLWIDTH(10), .DEVICE_WIDTH(4),
      .BL(BL), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .bg        (bg),
      .ba        (ba),
      .row       (row),
      .col       (col),
      .dqin      (dqin),
      .dqout     (dqout),
      .dq_valid  (dq_valid),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every read beat and every error pulse must match the scoreboard.
   always @(negedge clk) begin : mon
      beat_t e;
      if (rst_n) begin
         if (dq_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected dq_valid", int'(dq_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat data", int'(dqout), int'(e.d));
               chk("beat cycle", cyc, e.c);
            end
         end else begin
            chk("dqout idle zero", int'(dqout), 0);
         end
         if (cmd_err) begin
            if (err_q.size() == 0) chk("unexpected cmd_err", int'(cmd_err), 0);
            else                   chk("cmd_err cycle", cyc, err_q.pop_front());
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input cmd_t c, input int g, input int a, input int r, input int cl,
                        output int n);
      cmd_valid = 1'b1;
      cmd       = c;
      bg        = 2'(g);
      ba        = 2'(a);
      row       = 5'(r);
      col       = 10'(cl);
      n         = cyc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd       = NOP;
   endtask

   task automatic wr(input int g, input int a, input int cl, input logic [31:0] data);
      int n;
      issue(WR, g, a, 0, cl, n);
      idle(TCWL - 1);
      for (int k = 0; k < BL; k++) begin
         dqin = data[31-4*k -: 4];
         @(posedge clk);
         #1;
      end
      dqin = '0;
      chk("write ready return cycle", cyc, n + TCWL + BL);
      chk("ready after write", int'(cmd_ready), 1);
   endtask

   task automatic rd_start(input int g, input int a, input int cl, input logic [31:0] data,
                           input int keep, output int n);
      beat_t e;
      issue(RD, g, a, 0, cl, n);
      for (int k = 0; k < keep; k++) begin
         e.d = data[31-4*k -: 4];
         e.c = n + TCL + k;
         exp_q.push_back(e);
      end
      chk("ready low after rd", int'(cmd_ready), 0);
   endtask

   task automatic wait_ready(input int n);
      for (int i = 0; i < 64 && !cmd_ready; i++) begin
         @(posedge clk);
         #1;
      end
      chk("read ready return cycle", cyc, n + TCL + BL);
   endtask

   task automatic rd(input int g, input int a, input int cl, input logic [31:0] data);
      int n;
      rd_start(g, a, cl, data, BL, n);
      wait_ready(n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("reset cmd_ready", int'(cmd_ready), 1);
      chk("reset dq_valid", int'(dq_valid), 0);
      chk("reset dqout", int'(dqout), 0);
      chk("reset cmd_err", int'(cmd_err), 0);
      rst_n = 1'b1;
      idle(1);

      // Write then read back in order and with wrap from column 5.
      issue(ACT, 1, 1, 1, 0, n);
      idle(TRCD);
      wr(1, 1, 0, 32'h3A5C10F7);
      rd(1, 1, 0, 32'h3A5C10F7);
      rd(1, 1, 5, 32'h0F73A5C1);

      // Read to a closed bank, and a read before tRCD has elapsed.
      issue(RD, 2, 0, 0, 0, n);
      err_q.push_back(n + 1);
      chk("ready after illegal rd idle bank", int'(cmd_ready), 1);
      issue(ACT, 3, 0, 2, 0, n);
      issue(RD, 3, 0, 0, 0, n);
      err_q.push_back(n + 1);
      chk("ready after early rd", int'(cmd_ready), 1);
      idle(2);

      // Two rows of the same bank hold independent data.
      issue(ACT, 0, 0, 3, 0, n);
      idle(TRCD);
      wr(0, 0, 8, 32'h12345678);
      issue(PRE, 0, 0, 0, 0, n);
      issue(ACT, 0, 0, 4, 0, n);
      idle(TRCD);
      wr(0, 0, 8, 32'h9ABCDEF0);
      rd(0, 0, 8, 32'h9ABCDEF0);
      issue(ACT, 0, 0, 5, 0, n);
      err_q.push_back(n + 1);
      rd(0, 0, 8, 32'h9ABCDEF0);
      issue(PRE, 0, 0, 0, 0, n);
      issue(ACT, 0, 0, 3, 0, n);
      idle(TRCD);
      rd(0, 0, 8, 32'h12345678);

      // Commands offered while busy are ignored: no error, bank stays open.
      rd_start(1, 1, 0, 32'h3A5C10F7, BL, n);
      cmd_valid = 1'b1;
      cmd       = ACT;
      bg        = 2'd1;
      ba        = 2'd1;
      row       = 5'd7;
      idle(1);
      chk("ready low while busy", int'(cmd_ready), 0);
      cmd = PRE;
      idle(1);
      cmd_valid = 1'b0;
      cmd       = NOP;
      wait_ready(n);
      rd(1, 1, 5, 32'h0F73A5C1);

      // Reset during beat 3 of a read burst.
      rd_start(1, 1, 0, 32'h3A5C10F7, 3, n);
      idle(TCL + 2);
      rst_n = 1'b0;
      #1;
      chk("abort dq_valid", int'(dq_valid), 0);
      chk("abort cmd_ready", int'(cmd_ready), 1);
      chk("abort dqout", int'(dqout), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      issue(RD, 1, 1, 0, 0, n);
      err_q.push_back(n + 1);
      issue(ACT, 1, 1, 1, 0, n);
      idle(TRCD);
      rd(1, 1, 0, 32'h3A5C10F7);

      idle(4);
      chk("beats outstanding", exp_q.size(), 0);
      chk("errors outstanding", err_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/chip_burst.md
CHIP_BURST -- requirements
Module: chip_burst

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, bank-group address width.
REQ-002 SHALL have parameter BAWIDTH, default 2, bank-in-group address width.
REQ-003 SHALL have parameter CHWIDTH, default 5, row address width.
REQ-004 SHALL have parameter COLWIDTH, default 10, column address width.
REQ-005 SHALL have parameter DEVICE_WIDTH, default 4, data width per beat.
REQ-006 SHALL have parameter BL, default 8, burst length, a power of 2 and at most 2**COLWIDTH.
REQ-007 SHALL have parameters TRCD (default 2), TCL (default 3) and TCWL (default 1), all in clk cycles and each at least 1.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-009 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-010 SHALL have port cmd_valid, input, 1, command present.
REQ-011 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-012 SHALL have port cmd, input, cmd_t, one of NOP, ACT, RD, WR, PRE.
REQ-013 SHALL have ports bg (BGWIDTH), ba (BAWIDTH), row (CHWIDTH) and col (COLWIDTH), all inputs carrying the command address.
REQ-014 SHALL have port dqin, input, DEVICE_WIDTH, write beat data.
REQ-015 SHALL have port dqout, output, DEVICE_WIDTH, read beat data.
REQ-016 SHALL have port dq_valid, output, 1, dqout holds a valid read beat.
REQ-017 SHALL have port cmd_err, output, 1, one-cycle pulse on an illegal accepted command.

Function
REQ-018 SHALL hold, per bank, a state of IDLE or ACTIVE, an open-row register and a tRCD down-counter.
REQ-019 ACT to an IDLE bank SHALL move it to ACTIVE, latch row, and load the counter with TRCD.
REQ-020 PRE SHALL move the bank to IDLE; PRE to an IDLE bank SHALL be a legal no-op.
REQ-021 RD/WR SHALL be legal only to an ACTIVE bank whose counter is 0.
REQ-022 ACT to an ACTIVE bank, or RD/WR to an IDLE or not-yet-ready bank, SHALL pulse cmd_err the following cycle and cause no state, memory or data change.
REQ-023 NOP, or an accepted command while cmd_ready is low, SHALL have no effect.
REQ-024 A RD accepted at cycle N SHALL drive BL beats on cycles N+TCL through N+TCL+BL-1 with dq_valid high.
REQ-025 A WR accepted at cycle N SHALL sample dqin on cycles N+TCWL through N+TCWL+BL-1.
REQ-026 Beat k SHALL address column {col[COLWIDTH-1:log2 BL], (col[log2 BL-1:0]+k) mod BL}, i.e. sequential order wrapping inside the BL-aligned block.
REQ-027 Memory SHALL be addressed {bg, ba, open row, column}, with 2**(BGWIDTH+BAWIDTH+CHWIDTH+COLWIDTH) words of DEVICE_WIDTH bits.
REQ-028 cmd_ready SHALL go low the cycle after RD/WR acceptance and return high the cycle after the last beat; it SHALL otherwise be high.
REQ-029 tRCD counters SHALL decrement every cycle while cmd_ready is low, including during bursts to other banks.
REQ-030 dqout SHALL be 0 whenever dq_valid is low.

Reset
REQ-031 While rst_n is low: all banks IDLE, open rows 0, counters 0, cmd_ready 1, dq_valid 0, dqout 0, cmd_err 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; no further beats SHALL be written or driven.
REQ-033 The memory array SHALL NOT be reset; its contents SHALL persist across rst_n.

Structure
REQ-034 Package chip_pkg SHALL hold cmd_t (NOP, ACT, RD, WR, PRE) and bank_state_t (IDLE, ACTIVE).
REQ-035 Sub-module bank_fsm SHALL hold the per-bank state, open row and tRCD counter, instantiated BANKGROUPS*BANKSPERGROUP times.
REQ-036 The top level SHALL hold the single burst sequencer (states IDLE, LAT, BURST), the beat counter and the memory array.

Verification
REQ-037 ACT bg1 ba1 row1, wait TRCD, WR col0 with beats 3,A,5,C,1,0,F,7 -> then RD col0 -> dq_valid exactly TCL cycles after RD acceptance, beats 3,A,5,C,1,0,F,7, 8 consecutive cycles.
REQ-038 RD bg1 ba1 col 5 on the same data -> beats from columns 5,6,7,0,1,2,3,4 (C... wrap order: 0,F,7,3,A,5,C,1).
REQ-039 RD to bank bg2 ba0 while IDLE, or RD one cycle after ACT with TRCD=2 -> cmd_err pulse, no dq_valid, cmd_ready stays 1.
REQ-040 ACT to bg0 ba0 row 3, PRE, ACT row 4, RD -> data from row 4 only; a second ACT without PRE -> cmd_err.
REQ-041 Drop rst_n at beat 3 of a read burst -> dq_valid 0 and cmd_ready 1 immediately; after re-ACT, earlier-written data still reads back.
REQ-042 Commands with cmd_valid high during cmd_ready low -> ignored, no cmd_err, bank states unchanged.
